// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants for the buffered SPART
package spart_pkg;

  // register map
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  // parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // status bit indices
  localparam int ST_RDA         = 0;
  localparam int ST_TBR         = 1;
  localparam int ST_TX_IDLE     = 2;
  localparam int ST_PARITY_ERR  = 3;
  localparam int ST_FRAMING_ERR = 4;
  localparam int ST_OVERRUN     = 5;

  // transmitter states
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  // receiver states
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // parity bit that makes the frame match the selected mode
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    parity_bit = (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with extra-MSB pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a pop frees the slot a push needs, and a push supplies the word a pop takes
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  // when empty the head is the word being pushed this cycle
  assign rd_data = empty ? wr_data : mem[rd_ptr[AW-1:0]];

  // storage write; no reset needed on the data array
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // pointer update, wrapping through the extra MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spart_buf.sv
// rtl/spart_buf.sv - buffered SPART with TX/RX FIFOs and programmable baud
module spart_buf
  import spart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          PARITY     = 0,
  parameter logic [15:0] DIV_RESET  = 16'd162
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  logic        wr_en;
  logic        rd_en;
  logic        div_wr;
  logic        stat_rd;
  logic [7:0]  status;
  logic [7:0]  rd_mux;

  logic [15:0] divisor;
  logic [15:0] baud_cnt;
  logic        tick;

  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic [7:0]  tx_head;
  logic [2:0]  tx_state;
  logic [3:0]  tx_tick;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_data;
  logic        tx_par;
  logic        tx_idle;

  logic        rx_push;
  logic        rx_pop;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_head;
  logic [2:0]  rx_state;
  logic [3:0]  rx_tick;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_par_bad;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic        rx_fall;
  logic        rx_sample;
  logic        rx_stop_evt;

  logic        parity_err;
  logic        framing_err;
  logic        overrun;
  logic        pe_evt;
  logic        fe_evt;
  logic        ov_evt;

  assign wr_en   = iocs & ~iorw;
  assign rd_en   = iocs & iorw;
  assign div_wr  = wr_en & ioaddr[1];
  assign stat_rd = rd_en && (ioaddr == ADDR_STATUS);

  // ---------------- baud generator ----------------
  assign tick = (baud_cnt == divisor);

  // divisor bytes written through the two high addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor <= DIV_RESET;
    end else if (wr_en && ioaddr == ADDR_DIV_LO) begin
      divisor[7:0] <= databus;
    end else if (wr_en && ioaddr == ADDR_DIV_HI) begin
      divisor[15:8] <= databus;
    end
  end

  // free-running counter; restarts on every divisor write so new rates take effect cleanly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= 16'd0;
    end else if (div_wr || tick) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // ---------------- FIFOs ----------------
  assign tx_push = wr_en && (ioaddr == ADDR_DATA);
  assign rx_pop  = rd_en && (ioaddr == ADDR_DATA) && !rx_empty;
  assign rx_push = rx_stop_evt;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .wr_data (databus),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wr_data (rx_shift),
    .pop     (rx_pop),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // ---------------- transmitter ----------------
  // load a new byte from idle, or straight from the last stop tick so frames run back to back
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick == 4'd15));
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  // bit sequencing, 16 ticks per bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_data  <= 8'd0;
      tx_par   <= 1'b0;
    end else if (tick) begin
      if (tx_pop) begin
        tx_state <= TX_START;
        tx_tick  <= 4'd0;
        tx_data  <= tx_head;
        tx_par   <= parity_bit(tx_head, PARITY);
      end else if (tx_state == TX_IDLE) begin
        tx_tick <= 4'd0;
      end else if (tx_tick != 4'd15) begin
        tx_tick <= tx_tick + 4'd1;
      end else begin
        tx_tick <= 4'd0;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= 3'd0;
          end
          TX_DATA: begin
            if (tx_bit == 3'd7) begin
              tx_state <= (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
            end
          end
          TX_PARITY: tx_state <= TX_STOP;
          default:   tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // line level follows the state, so reset drives it high at once
  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_data[tx_bit];
      TX_PARITY: txd = tx_par;
      default:   txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  // two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall     = rx_prev & ~rx_s2;
  // start bit is checked half a bit in; every later bit one full bit after that
  assign rx_sample   = tick && ((rx_state == RX_START) ? (rx_tick == 4'd7) : (rx_tick == 4'd15));
  assign rx_stop_evt = rx_sample && (rx_state == RX_STOP);

  // frame reception, sampling mid-bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_tick    <= 4'd0;
      rx_bit     <= 3'd0;
      rx_shift   <= 8'd0;
      rx_par_bad <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      if (rx_fall) begin
        rx_state <= RX_START;
        rx_tick  <= 4'd0;
      end
    end else if (tick) begin
      if (!rx_sample) begin
        rx_tick <= rx_tick + 4'd1;
      end else begin
        rx_tick <= 4'd0;
        case (rx_state)
          RX_START: begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state   <= RX_DATA;
              rx_bit     <= 3'd0;
              rx_par_bad <= 1'b0;
            end
          end
          RX_DATA: begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end
          RX_PARITY: begin
            rx_par_bad <= (rx_s2 != parity_bit(rx_shift, PARITY));
            rx_state   <= RX_STOP;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- errors and status ----------------
  assign pe_evt = rx_stop_evt && rx_par_bad;
  assign fe_evt = rx_stop_evt && !rx_s2;
  assign ov_evt = rx_stop_evt && rx_full && !rx_pop;

  // sticky error flags, cleared by a status read unless a new event lands the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      parity_err  <= pe_evt | (parity_err & ~stat_rd);
      framing_err <= fe_evt | (framing_err & ~stat_rd);
      overrun     <= ov_evt | (overrun & ~stat_rd);
    end
  end

  assign rda = !rx_empty;
  assign tbr = !tx_full;

  always_comb begin
    status                 = 8'd0;
    status[ST_RDA]         = rda;
    status[ST_TBR]         = tbr;
    status[ST_TX_IDLE]     = tx_idle;
    status[ST_PARITY_ERR]  = parity_err;
    status[ST_FRAMING_ERR] = framing_err;
    status[ST_OVERRUN]     = overrun;
  end

  // read data selected combinationally from the address
  always_comb begin
    rd_mux = 8'd0;
    case (ioaddr)
      ADDR_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS: rd_mux = status;
      ADDR_DIV_LO: rd_mux = divisor[7:0];
      default:     rd_mux = divisor[15:8];
    endcase
  end

  assign databus = rd_en ? rd_mux : 8'hzz;

endmodule

// File: tb/tb_spart_buf.sv
// tb/tb_spart_buf.sv - self-checking bench for spart_buf
module tb_spart_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, cs_a, cs_b, rw, drv_a, drv_b;
  logic [1:0] addr;
  logic [7:0] wdata;
  wire  [7:0] bus_a, bus_b;
  logic       rda_a, tbr_a, txd_a, rda_b, tbr_b, txd_b;
  logic       rx_drv_a, rx_drv_b, loop_a, loop_b;
  wire        rxd_a, rxd_b;

  assign bus_a = drv_a ? wdata : 8'hzz;
  assign bus_b = drv_b ? wdata : 8'hzz;
  assign rxd_a = loop_a ? txd_a : rx_drv_a;
  assign rxd_b = loop_b ? txd_b : rx_drv_b;

  spart_buf #(.FIFO_DEPTH(4), .PARITY(0), .DIV_RESET(16'd162)) dut_a (
    .clk(clk), .rst(rst_a), .iocs(cs_a), .iorw(rw), .ioaddr(addr), .databus(bus_a),
    .rda(rda_a), .tbr(tbr_a), .txd(txd_a), .rxd(rxd_a)
  );

  spart_buf #(.FIFO_DEPTH(8), .PARITY(1), .DIV_RESET(16'd162)) dut_b (
    .clk(clk), .rst(rst_b), .iocs(cs_b), .iorw(rw), .ioaddr(addr), .databus(bus_b),
    .rda(rda_b), .tbr(tbr_b), .txd(txd_b), .rxd(rxd_b)
  );

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic       rd;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[15];
  logic [7:0] q8;
  logic [7:0] w5[5];
  logic [7:0] model_q[$];
  int         tbr_falls;
  logic       tbr_prev;
  bit         mon_en = 0;

  // count falling edges of the A transmit-ready flag while monitoring
  always @(negedge clk) begin
    if (mon_en) begin
      if (tbr_prev && !tbr_a) tbr_falls++;
      tbr_prev = tbr_a;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-cycle bus access; call just after a rising edge
  task automatic bus_acc(input bit sel, input bit rdx, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    cs_a = !sel; cs_b = sel; rw = rdx; addr = a; wdata = d;
    drv_a = !rdx && !sel; drv_b = !rdx && sel;
    @(negedge clk);
    q = sel ? bus_b : bus_a;
    @(posedge clk); #1;
    cs_a = 0; cs_b = 0; drv_a = 0; drv_b = 0;
  endtask

  task automatic bus_wr(input bit sel, input logic [1:0] a, input logic [7:0] d);
    logic [7:0] unused;
    bus_acc(sel, 1'b0, a, d, unused);
  endtask

  task automatic bus_rd(input bit sel, input logic [1:0] a, output logic [7:0] q);
    bus_acc(sel, 1'b1, a, 8'h00, q);
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_drv_b = v; else rx_drv_a = v;
  endtask

  // serial frame at divisor 0 (16 clocks per bit)
  task automatic send_frame(input bit sel, input logic [7:0] b, input bit has_par,
                            input logic pbit, input logic stopb);
    set_rx(sel, 1'b0); clks(16);
    for (int i = 0; i < 8; i++) begin set_rx(sel, b[i]); clks(16); end
    if (has_par) begin set_rx(sel, pbit); clks(16); end
    set_rx(sel, stopb); clks(16);
    set_rx(sel, 1'b1); clks(4);
  endtask

  task automatic wait_txd_low(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!txd_a) ok = 1;
    end
  endtask

  initial begin
    bit         ok;
    int         bad;
    logic       expb;
    logic [9:0] frame;
    int         d, n;

    rst_a = 0; rst_b = 0; cs_a = 0; cs_b = 0; rw = 1; drv_a = 0; drv_b = 0;
    addr = 0; wdata = 0; rx_drv_a = 1; rx_drv_b = 1; loop_a = 0; loop_b = 1;

    tbl[0]  = '{1'b1, 2'b01, 8'h00, 8'h06};
    tbl[1]  = '{1'b1, 2'b10, 8'h00, 8'hA2};
    tbl[2]  = '{1'b1, 2'b11, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 2'b00, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 2'b10, 8'h34, 8'h00};
    tbl[5]  = '{1'b1, 2'b10, 8'h00, 8'h34};
    tbl[6]  = '{1'b0, 2'b11, 8'h12, 8'h00};
    tbl[7]  = '{1'b1, 2'b11, 8'h00, 8'h12};
    tbl[8]  = '{1'b1, 2'b10, 8'h00, 8'h34};
    tbl[9]  = '{1'b0, 2'b01, 8'hFF, 8'h00};
    tbl[10] = '{1'b1, 2'b01, 8'h00, 8'h06};
    tbl[11] = '{1'b0, 2'b10, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 2'b11, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 2'b10, 8'h00, 8'h00};
    tbl[14] = '{1'b1, 2'b11, 8'h00, 8'h00};
    w5 = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd_a", txd_a, 1); chk("rst_rda_a", rda_a, 0); chk("rst_tbr_a", tbr_a, 1);
    chk("rst_txd_b", txd_b, 1); chk("rst_rda_b", rda_b, 0);
    @(posedge clk); #1; rst_a = 1; rst_b = 1;
    clks(2);

    // register access table on A
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rd) begin
        bus_rd(0, tbl[i].a, q8);
        chk($sformatf("tbl%0d", i), q8, tbl[i].exp);
      end else begin
        bus_wr(0, tbl[i].a, tbl[i].d);
      end
    end

    // A5 transmitted at divisor 0, no parity
    bus_wr(0, 2'b00, 8'hA5);
    wait_txd_low(ok);
    chk("tx_start_seen", ok, 1);
    frame = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    for (int i = 1; i < 160; i++) begin
      @(negedge clk);
      expb = frame[i / 16];
      if (txd_a !== expb) bad++;
    end
    chk("tx_a5_waveform", bad, 0);
    @(posedge clk); #1;
    bus_rd(0, 2'b01, q8);
    chk("tx_idle_after_frame", q8, 8'h06);

    // glitch rejected, then a frame with a bad stop bit
    rx_drv_a = 0; clks(5); rx_drv_a = 1; clks(40);
    chk("glitch_no_rda", rda_a, 0);
    bus_rd(0, 2'b01, q8);
    chk("glitch_status", q8, 8'h06);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b0);
    chk("framing_rda", rda_a, 1);
    bus_rd(0, 2'b01, q8);
    chk("framing_status", q8, 8'h17);
    bus_rd(0, 2'b00, q8);
    chk("framing_byte", q8, 8'h5A);

    // overrun: nine frames into a four-deep FIFO
    for (int k = 1; k <= 9; k++) send_frame(0, 8'(k * 17), 0, 1'b0, 1'b1);
    bus_wr(0, 2'b00, 8'h55);
    bus_rd(0, 2'b01, q8);
    chk("overrun_status1", q8, 8'h23);
    bus_rd(0, 2'b01, q8);
    chk("overrun_status2", q8, 8'h03);
    clks(200);
    for (int k = 1; k <= 4; k++) begin
      bus_rd(0, 2'b00, q8);
      chk($sformatf("overrun_byte%0d", k), q8, 8'(k * 17));
    end
    bus_rd(0, 2'b00, q8);
    chk("empty_read", q8, 8'h00);

    // reset in the middle of a data bit
    bus_wr(0, 2'b00, 8'h00);
    wait_txd_low(ok);
    chk("tx2_start_seen", ok, 1);
    repeat (40) @(negedge clk);
    chk("mid_data_low", txd_a, 0);
    #1 rst_a = 0;
    #1 chk("rst_mid_txd", txd_a, 1);
    chk("rst_mid_tbr", tbr_a, 1);
    clks(2); rst_a = 1; clks(1);
    bus_rd(0, 2'b01, q8);
    chk("rst_mid_status", q8, 8'h06);
    bus_rd(0, 2'b10, q8);
    chk("rst_mid_div", q8, 8'hA2);

    // five back-to-back writes into a four-deep TX FIFO, looped back
    loop_a = 1;
    tbr_falls = 0; tbr_prev = 1; mon_en = 1;
    bus_wr(0, 2'b10, 8'd5);
    bus_wr(0, 2'b11, 8'd0);
    for (int k = 0; k < 5; k++) bus_wr(0, 2'b00, w5[k]);
    @(negedge clk);
    chk("burst_tbr_low", tbr_a, 0);
    @(negedge clk);
    chk("burst_pop_on_tick", tbr_a, 1);
    @(posedge clk); #1;
    clks(4200);
    mon_en = 0;
    chk("burst_tbr_windows", tbr_falls, 1);
    for (int k = 0; k < 4; k++) begin
      bus_rd(0, 2'b00, q8);
      chk($sformatf("burst_byte%0d", k), q8, w5[k]);
    end
    bus_rd(0, 2'b00, q8);
    chk("burst_fifth_dropped", q8, 8'h00);
    bus_rd(0, 2'b01, q8);
    chk("burst_status", q8, 8'h06);

    // even parity loopback on B
    bus_wr(1, 2'b10, 8'd0);
    bus_wr(1, 2'b11, 8'd0);
    bus_wr(1, 2'b00, 8'h3C);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rda_b) ok = 1;
    end
    chk("par_rda_rise", ok, 1);
    @(posedge clk); #1;
    bus_rd(1, 2'b00, q8);
    chk("par_byte", q8, 8'h3C);
    clks(16);
    bus_rd(1, 2'b01, q8);
    chk("par_status", q8, 8'h06);

    // random loopback bursts against a queue model
    for (int r = 0; r < 4; r++) begin
      d = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 8));
      bus_wr(1, 2'b10, 8'(d));
      bus_wr(1, 2'b11, 8'd0);
      for (int k = 0; k < n; k++) begin
        q8 = 8'($urandom);
        model_q.push_back(q8);
        bus_wr(1, 2'b00, q8);
      end
      clks(n * 176 * (d + 1) + 300);
      bus_rd(1, 2'b01, q8);
      chk($sformatf("rand%0d_status", r), q8, 8'h07);
      while (model_q.size() > 0) begin
        bus_rd(1, 2'b00, q8);
        chk($sformatf("rand%0d_byte", r), q8, model_q.pop_front());
      end
      bus_rd(1, 2'b01, q8);
      chk($sformatf("rand%0d_drained", r), q8, 8'h06);
    end

    // wrong parity bit driven into B
    loop_b = 0;
    bus_wr(1, 2'b10, 8'd0);
    send_frame(1, 8'hA7, 1, 1'b0, 1'b1);
    bus_rd(1, 2'b01, q8);
    chk("parity_err_status", q8, 8'h0F);
    bus_rd(1, 2'b00, q8);
    chk("parity_err_byte", q8, 8'hA7);
    bus_rd(1, 2'b01, q8);
    chk("parity_err_cleared", q8, 8'h06);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
